host_uart_command_enc: RTL and testbench

HOST_UART_COMMAND_ENC -- requirements
Module: host_uart_command_enc

---
 rtl/host_uart_command_enc.sv | 151 +++++++++++++++
 tb/tb_host_uart_command_enc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/host_uart_command_enc.sv
// Response-frame encoder for a UART transmitter: ID, six 0xFF markers, length, payload.
// Optional trailing XOR checksum byte when HOST_UART_ENC_CHECKSUM_EN is defined.
module host_uart_command_enc (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [15:0]  cmd_select,
  input  logic [255:0] input_data,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  output logic         done,
  output logic         error,
  output logic [1:0]   state_dbg
);

  // Handshake: a byte moves on a rising edge where tx_valid && tx_ready; while
  // tx_valid is high and tx_ready low, tx_data and the FSM hold unchanged.

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CSUM    = 2'd3;

`ifdef HOST_UART_ENC_CHECKSUM_EN
  localparam logic [1:0] ST_AFTER_DATA = ST_CSUM;
`else
  localparam logic [1:0] ST_AFTER_DATA = ST_IDLE;
`endif

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [7:0]  id_q;
  logic [2:0]  len_q;
  logic [47:0] payload_q;
`ifdef HOST_UART_ENC_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        cmd_ok;
  logic [7:0]  id_d;
  logic [2:0]  len_d;
  logic [47:0] payload_d;
  logic [47:0] payload_shift;
  logic        xfer;
  logic        unused_bits;

  assign unused_bits = ^input_data[255:48];

  always_comb begin
    cmd_ok    = 1'b1;
    id_d      = 8'h00;
    len_d     = 3'd0;
    payload_d = 48'h0;
    case (cmd_select)
      16'h0001: begin id_d = 8'h01; len_d = 3'd1; payload_d = 48'h00; end
      16'h0002: begin id_d = 8'h01; len_d = 3'd1; payload_d = 48'h01; end
      16'h0003: begin id_d = 8'h03; len_d = 3'd6; payload_d = input_data[47:0]; end
      16'hFFFF: begin id_d = 8'hFF; len_d = 3'd0; end
      default:  cmd_ok = 1'b0;
    endcase
  end

  // Payload byte 0 is the least-significant byte of the latched data.
  assign payload_shift = payload_q >> {cnt, 3'b000};

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_HDR: begin
        if (cnt == 3'd0)      tx_data = id_q;
        else if (cnt == 3'd7) tx_data = {5'd0, len_q};
        else                  tx_data = 8'hFF;
      end
      ST_PAYLOAD: tx_data = payload_shift[7:0];
`ifdef HOST_UART_ENC_CHECKSUM_EN
      ST_CSUM:    tx_data = csum_q;
`endif
      default:    tx_data = 8'h00;
    endcase
  end

  assign tx_valid  = (state != ST_IDLE);
  assign done      = (state == ST_IDLE);
  assign state_dbg = state;
  assign xfer      = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      id_q      <= 8'h00;
      len_q     <= 3'd0;
      payload_q <= 48'h0;
      error     <= 1'b0;
`ifdef HOST_UART_ENC_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
`ifdef HOST_UART_ENC_CHECKSUM_EN
      if (xfer && state != ST_CSUM) csum_q <= csum_q ^ tx_data;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cmd_ok) begin
              id_q      <= id_d;
              len_q     <= len_d;
              payload_q <= payload_d;
              error     <= 1'b0;
              cnt       <= 3'd0;
              state     <= ST_HDR;
`ifdef HOST_UART_ENC_CHECKSUM_EN
              csum_q    <= 8'h00;
`endif
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          if (xfer) begin
            if (cnt == 3'd7) begin
              cnt   <= 3'd0;
              state <= (len_q != 3'd0) ? ST_PAYLOAD : ST_AFTER_DATA;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (xfer) begin
            if (cnt == len_q - 3'd1) begin
              cnt   <= 3'd0;
              state <= ST_AFTER_DATA;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: begin
          if (xfer) begin
            cnt   <= 3'd0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_uart_command_enc.sv
// Directed bench for host_uart_command_enc: frame bytes, stalls, error, reset abort, ignored start.
module tb_host_uart_command_enc;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  cmd_select;
  logic [255:0] input_data;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         done;
  logic         error;
  logic [1:0]   state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  host_uart_command_enc dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cmd_select (cmd_select),
    .input_data (input_data),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .done       (done),
    .error      (error),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Hand-written frame contents; checksum appended as XOR of the listed bytes.
  task automatic build_frame(input logic [15:0] cmd, input logic [47:0] data);
    logic [7:0] x;
    exp_q.delete();
    case (cmd)
      16'h0001: exp_q = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00};
      16'h0002: exp_q = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01};
      16'h0003: begin
        exp_q = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h06};
        for (int i = 0; i < 6; i++) exp_q.push_back(data[i*8 +: 8]);
      end
      default:  exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    endcase
`ifdef HOST_UART_ENC_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then scramble command inputs to show they were latched.
  task automatic send_start(input logic [15:0] cmd, input logic [47:0] data);
    cmd_select = cmd;
    input_data = {208'h0, data};
    start = 1'b1;
    tick();
    start = 1'b0;
    cmd_select = 16'h0007;
    input_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Drain exp_q one cycle at a time; optional tx_ready toggling and a mid-frame start poke.
  task automatic run_frame(input string tag, input bit toggle, input int poke_at);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 64) begin
      tx_ready = toggle ? (k % 2 == 0) : 1'b1;
      start = (k == poke_at);
      if (k == poke_at) cmd_select = 16'h0003;
      @(negedge clk);
      check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
      check({tag, "_data"},  {24'd0, tx_data},  {24'd0, exp_q[0]});
      check({tag, "_busy"},  {31'd0, done},     32'd0);
      tick();
      if (tx_ready) void'(exp_q.pop_front());
      k++;
    end
    start = 1'b0;
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    check({tag, "_end_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_end_done"},  {31'd0, done},     32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd_select = 16'h0; input_data = '0; tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data",  {24'd0, tx_data},  32'd0);
    check("rst_done",  {31'd0, done},     32'd1);
    check("rst_error", {31'd0, error},    32'd0);
    reset = 1'b0;
    tick();

    // cmd 2, always ready; then immediate back-to-back start of cmd FFFF
    build_frame(16'h0002, 48'h0);
    send_start(16'h0002, 48'h0);
    run_frame("cmd2", 1'b0, -1);
    build_frame(16'hFFFF, 48'h0);
    send_start(16'hFFFF, 48'h0);
    run_frame("cmdffff", 1'b0, -1);

    // cmd 3 with stalls
    build_frame(16'h0003, 48'h665544332211);
    send_start(16'h0003, 48'h665544332211);
    run_frame("cmd3_stall", 1'b1, -1);

    // unsupported command
    tx_ready = 1'b1;
    send_start(16'h0007, 48'h0);
    check("bad_error", {31'd0, error},    32'd1);
    check("bad_done",  {31'd0, done},     32'd1);
    check("bad_valid", {31'd0, tx_valid}, 32'd0);
    tick();
    check("bad_hold_error", {31'd0, error},    32'd1);
    check("bad_hold_valid", {31'd0, tx_valid}, 32'd0);
    build_frame(16'h0001, 48'h0);
    send_start(16'h0001, 48'h0);
    check("clr_error", {31'd0, error}, 32'd0);
    run_frame("cmd1", 1'b0, -1);

    // reset after byte 3 of a cmd 3 frame, with start asserted alongside reset
    send_start(16'h0003, 48'hA1B2C3D4E5F6);
    tx_ready = 1'b1;
    repeat (4) tick();
    check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
    check("pre_rst_data",  {24'd0, tx_data},  32'hFF);
    reset = 1'b1; start = 1'b1; cmd_select = 16'h0002;
    tick();
    reset = 1'b0; start = 1'b0;
    check("abort_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_done",  {31'd0, done},     32'd1);
    check("abort_data",  {24'd0, tx_data},  32'd0);
    tick();
    check("abort_idle_valid", {31'd0, tx_valid}, 32'd0);
    build_frame(16'h0001, 48'h0);
    send_start(16'h0001, 48'h0);
    run_frame("after_rst", 1'b0, -1);

    // start pulsed mid-frame is ignored
    build_frame(16'hFFFF, 48'h0);
    send_start(16'hFFFF, 48'h0);
    run_frame("poke", 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_second_frame", {31'd0, tx_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
